// File: rtl/adder_ring_meter_pkg.sv
// adder_ring_meter_pkg: shared states, default widths and drain length for the ring meter
package adder_ring_meter_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF = 32;
  localparam int WIN_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int drain_len(input int sync_stages);
    return sync_stages + 1;
  endfunction
endpackage

// File: rtl/ring_edge_sync.sv
// ring_edge_sync: synchronises the asynchronous ring output and flags its rising edges
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ring_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic last;
  // shift the synchroniser chain every cycle and keep the previous synchronised level
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ring_in};
      last <= sync[SYNC_STAGES-1];
    end
  assign rise = sync[SYNC_STAGES-1] & ~last;
endmodule

// File: rtl/adder_ring_meter.sv
// adder_ring_meter: counts synchronised ring edges over a programmed window and hands back the count
module adder_ring_meter
  import adder_ring_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic             ring_in,
  output logic             ring_enable,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);
  localparam logic [WIN_W-1:0] DRAIN_CYC = WIN_W'(drain_len(SYNC_STAGES));
  state_t state, state_nx;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt;
  logic ovf, rise, counting, last_cyc, accept;
  ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .ring_in(ring_in),
    .rise(rise)
  );
  assign counting = state == RUN || state == DRAIN;
  assign last_cyc = win_cnt == WIN_W'(1);
  assign accept = state == IDLE && start;
  assign result = cnt;
  assign overflow = ovf;
  // state register
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_nx;
  // next state and state-decoded outputs; abort overrides every transition
  always_comb begin
    state_nx = abort ? IDLE :
               state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (last_cyc ? DRAIN : RUN) :
               state == DRAIN ? (last_cyc ? DONE : DRAIN) :
               (result_ready ? IDLE : DONE);
    ring_enable = state == RUN;
    busy = counting;
    result_valid = state == DONE;
  end
  // window/drain countdown and saturating edge counter, frozen outside RUN and DRAIN
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i || abort) begin
      win_cnt <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      win_cnt <= window_cycles == '0 ? WIN_W'(1) : window_cycles;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (counting) begin
      win_cnt <= last_cyc ? (state == RUN ? DRAIN_CYC : '0) : win_cnt - WIN_W'(1);
      if (rise) begin
        cnt <= &cnt ? cnt : cnt + CNT_W'(1);
        ovf <= ovf | &cnt;
      end
    end
endmodule
